singcyc_data_bus: RTL and testbench

Data-side responder for the single-cycle MIPS core: it receives the core's data address, read strobe, write strobe and write data, and returns read data in the same cycle. It decodes the address into a word-addressed data RAM and a memory-mapped peripheral page. The page holds a reloading timer with an interrupt flag, an LED register, a 7-segment digit register, a synchronised switch input and a free-running cycle counter. It sits between the core's data port and the board I/O.

---
 rtl/singcyc_data_bus.sv | 119 +++++++++++
 tb/tb_singcyc_data_bus.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/singcyc_data_bus.sv
// Data-side responder for the single-cycle MIPS core: word RAM plus a
// memory-mapped page (timer, LED, 7-seg, switches, cycle counter).
module singcyc_data_bus #(
  parameter int RAM_WORDS = 256
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iAddr,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  input  logic [7:0]  iSwitch,
  output logic [7:0]  oLed,
  output logic [11:0] oDigi,
  output logic        oIrq
);

  localparam int AW = $clog2(RAM_WORDS);
  // 0x40000000 >> 5: the peripheral page occupies one 32-byte block
  localparam logic [26:0] PAGE = 27'h200_0000;

  typedef enum logic [2:0] {
    R_TH   = 3'd0,
    R_TL   = 3'd1,
    R_TCON = 3'd2,
    R_LED  = 3'd3,
    R_SW   = 3'd4,
    R_DIGI = 3'd5,
    R_SYS  = 3'd6
  } reg_e;

  typedef struct packed {
    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [7:0]  led;
    logic [11:0] digi;
    logic [31:0] sys;
    logic [7:0]  sw1;
    logic [7:0]  sw2;
  } periph_t;

  periph_t     pr_q, pr_d;
  logic [31:0] mem_q [RAM_WORDS];

  logic        ram_hit, pg_hit, ovf;
  logic [2:0]  reg_sel;
  logic [AW-1:0] ram_idx;
  logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
  logic [1:0]  unused_addr_lsb;

  assign unused_addr_lsb = iAddr[1:0];
  assign ram_idx = iAddr[AW+1:2];
  assign reg_sel = iAddr[4:2];
  assign ram_hit = (iAddr[31:AW+2] == '0);
  assign pg_hit  = (iAddr[31:5] == PAGE) && (reg_sel != 3'd7);

  assign wr_th   = iMemWrite && pg_hit && (reg_sel == R_TH);
  assign wr_tl   = iMemWrite && pg_hit && (reg_sel == R_TL);
  assign wr_tcon = iMemWrite && pg_hit && (reg_sel == R_TCON);
  assign wr_led  = iMemWrite && pg_hit && (reg_sel == R_LED);
  assign wr_digi = iMemWrite && pg_hit && (reg_sel == R_DIGI);

  assign ovf = pr_q.tcon[0] && (pr_q.tl == 32'hFFFF_FFFF);

  // RAM is deliberately outside the reset domain so contents survive iRst_n
  always_ff @(posedge iClk) begin
    if (iMemWrite && ram_hit) mem_q[ram_idx] <= iWrData;
  end

  always_comb begin
    pr_d     = pr_q;
    pr_d.sys = pr_q.sys + 32'd1;
    pr_d.sw1 = iSwitch;
    pr_d.sw2 = pr_q.sw1;

    // Reload reads the pre-edge TH, so a same-cycle TH write affects only the next wrap
    if (pr_q.tcon[0]) pr_d.tl = ovf ? pr_q.th : pr_q.tl + 32'd1;
    if (wr_tl)        pr_d.tl = iWrData;
    if (wr_th)        pr_d.th = iWrData;

    if (wr_tcon) pr_d.tcon = iWrData[2:0];
    if (ovf && pr_q.tcon[1]) pr_d.tcon[2] = 1'b1;

    if (wr_led)  pr_d.led  = iWrData[7:0];
    if (wr_digi) pr_d.digi = iWrData[11:0];
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) pr_q <= '0;
    else         pr_q <= pr_d;
  end

  always_comb begin
    oRdData = '0;
    if (iMemRead) begin
      if (ram_hit) begin
        oRdData = mem_q[ram_idx];
      end else if (pg_hit) begin
        case (reg_sel)
          R_TH:    oRdData = pr_q.th;
          R_TL:    oRdData = pr_q.tl;
          R_TCON:  oRdData = {29'd0, pr_q.tcon};
          R_LED:   oRdData = {24'd0, pr_q.led};
          R_SW:    oRdData = {24'd0, pr_q.sw2};
          R_DIGI:  oRdData = {20'd0, pr_q.digi};
          R_SYS:   oRdData = pr_q.sys;
          default: oRdData = '0;
        endcase
      end
    end
  end

  assign oLed  = pr_q.led;
  assign oDigi = pr_q.digi;
  assign oIrq  = pr_q.tcon[2];

endmodule

// File: tb/tb_singcyc_data_bus.sv
// Scoreboard bench for singcyc_data_bus: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_singcyc_data_bus;

  localparam int RAM_WORDS = 256;
  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_SYS  = 32'h4000_0018;

  localparam int K_RD = 0, K_LED = 1, K_DIGI = 2, K_IRQ = 3, K_CAP = 4, K_DELTA = 5;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic [31:0] iAddr = '0;
  logic        iMemRead = 1'b0;
  logic        iMemWrite = 1'b0;
  logic [31:0] iWrData = '0;
  logic [31:0] oRdData;
  logic [7:0]  iSwitch = '0;
  logic [7:0]  oLed;
  logic [11:0] oDigi;
  logic        oIrq;

  singcyc_data_bus #(.RAM_WORDS(RAM_WORDS)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iAddr(iAddr), .iMemRead(iMemRead),
    .iMemWrite(iMemWrite), .iWrData(iWrData), .oRdData(oRdData),
    .iSwitch(iSwitch), .oLed(oLed), .oDigi(oDigi), .oIrq(oIrq)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tick_cap = '0;

  task automatic push(input int k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k; e.val = v; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d);
    @(posedge iClk); #1;
    iAddr = a; iMemRead = r; iMemWrite = w; iWrData = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, 1'b0, 1'b1, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    drive(a, 1'b1, 1'b0, 32'd0);
    push(K_RD, e, n);
  endtask

  task automatic idle();
    drive(32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  always @(negedge iClk) begin
    while (sbq.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sbq.pop_front();
      act = '0;
      case (e.kind)
        K_RD:    act = oRdData;
        K_LED:   act = {24'd0, oLed};
        K_DIGI:  act = {20'd0, oDigi};
        K_IRQ:   act = {31'd0, oIrq};
        K_DELTA: act = oRdData - tick_cap;
        default: act = '0;
      endcase
      if (e.kind == K_CAP) begin
        tick_cap = oRdData;
      end else begin
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    // Reset state, with a read strobed during reset
    #1;
    iAddr = A_TL; iMemRead = 1'b1;
    push(K_RD, 32'd0, "reset_tl");
    push(K_LED, 32'd0, "reset_led");
    push(K_DIGI, 32'd0, "reset_digi");
    push(K_IRQ, 32'd0, "reset_irq");
    #12 iRst_n = 1'b1;

    // RAM basics, byte-offset ignored, same-cycle read/write
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF, "ram_rd_10");
    rd(32'h13, 32'hDEAD_BEEF, "ram_rd_13");
    wr(32'h14, 32'h1111_1111);
    drive(32'h14, 1'b1, 1'b1, 32'h2222_2222);
    push(K_RD, 32'h1111_1111, "ram_rw_old");
    rd(32'h14, 32'h2222_2222, "ram_rw_new");
    // Just past RAM end must not alias word 0
    wr(32'h0, 32'hCAFE_0001);
    wr(32'h400, 32'h1234_5678);
    rd(32'h0, 32'hCAFE_0001, "ram_no_alias");
    rd(32'h400, 32'h0, "ram_end_unmapped");

    // Timer overflow and reload
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd(A_TL, 32'hFFFF_FFFE, "tl_fe");       push(K_IRQ, 0, "irq_pre0");
    rd(A_TL, 32'hFFFF_FFFF, "tl_ff");       push(K_IRQ, 0, "irq_pre1");
    rd(A_TL, 32'hFFFF_FFFC, "tl_reload");   push(K_IRQ, 1, "irq_rise");
    rd(A_TCON, 32'd7, "tcon_flag");         push(K_IRQ, 1, "irq_hold");
    wr(A_TCON, 32'd3);
    rd(A_TCON, 32'd3, "tcon_clr");          push(K_IRQ, 0, "irq_cleared");
    rd(A_TL, 32'hFFFF_FFFC, "tl_reload2");  push(K_IRQ, 1, "irq_rise2");
    // Software clear in the overflow cycle loses to the hardware set
    rd(A_TL, 32'hFFFF_FFFD, "tl_fd");
    rd(A_TL, 32'hFFFF_FFFE, "tl_fe2");
    wr(A_TCON, 32'd3);                      push(K_IRQ, 1, "irq_ovf_cyc");
    rd(A_TCON, 32'd7, "tcon_set_wins");     push(K_IRQ, 1, "irq_set_wins");
    // TH write in the overflow cycle: reload uses old TH
    rd(A_TL, 32'hFFFF_FFFD, "tl_fd2");
    rd(A_TL, 32'hFFFF_FFFE, "tl_fe3");
    wr(A_TH, 32'h0000_0100);
    rd(A_TL, 32'hFFFF_FFFC, "tl_old_th");
    rd(A_TH, 32'h0000_0100, "th_new");
    // CPU write to TL beats the increment
    wr(A_TL, 32'd5);
    rd(A_TL, 32'd5, "tl_wr5");
    rd(A_TL, 32'd6, "tl_inc6");
    wr(A_TCON, 32'd0);
    rd(A_TCON, 32'd0, "tcon_off");          push(K_IRQ, 0, "irq_off");
    rd(A_TL, 32'd8, "tl_stop0");
    rd(A_TL, 32'd8, "tl_stop1");

    // LED / DIGI, then ignored writes
    wr(A_LED, 32'h1A5);
    wr(A_DIGI, 32'hF7E);
    rd(A_LED, 32'hA5, "led_rd");            push(K_LED, 32'hA5, "led_out");
    rd(A_DIGI, 32'hF7E, "digi_rd");         push(K_DIGI, 32'hF7E, "digi_out");
    wr(A_SW, 32'hFFFF_FFFF);
    wr(32'h4000_0020, 32'hFFFF_FFFF);
    wr(32'h4000_001C, 32'hFFFF_FFFF);
    rd(32'h4000_0020, 32'd0, "unmapped_20");
    rd(32'h4000_001C, 32'd0, "unmapped_1c");
    rd(A_SW, 32'd0, "sw_ro");               push(K_LED, 32'hA5, "led_kept");
    rd(A_TH, 32'h100, "th_kept");           push(K_DIGI, 32'hF7E, "digi_kept");
    rd(A_TL, 32'd8, "tl_kept");             push(K_IRQ, 0, "irq_kept");

    // SYSTICK delta over 7 cycles, with an ignored write in between
    drive(A_SYS, 1'b1, 1'b0, 32'd0);        push(K_CAP, 0, "sys_cap");
    wr(A_SYS, 32'd0);
    repeat (5) idle();
    drive(A_SYS, 1'b1, 1'b0, 32'd0);        push(K_DELTA, 32'd7, "sys_delta");

    // Switch synchroniser: two edges of latency
    rd(A_SW, 32'd0, "sw_edge0");
    iSwitch = 8'h3C;
    rd(A_SW, 32'd0, "sw_edge1");
    rd(A_SW, 32'h3C, "sw_edge2");

    // Asynchronous reset between edges, mid-count
    wr(A_TCON, 32'd7);
    rd(A_TL, 32'd8, "tl_pre_rst");          push(K_IRQ, 1, "irq_pre_rst");
    @(posedge iClk); #2;
    iRst_n = 1'b0; iAddr = A_TL; iMemRead = 1'b1; iMemWrite = 1'b0;
    push(K_RD, 32'd0, "rst_tl");
    push(K_LED, 32'd0, "rst_led");
    push(K_DIGI, 32'd0, "rst_digi");
    push(K_IRQ, 32'd0, "rst_irq");
    @(posedge iClk); #3;
    iRst_n = 1'b1;
    rd(32'h10, 32'hDEAD_BEEF, "ram_kept_10");
    rd(32'h14, 32'h2222_2222, "ram_kept_14");
    rd(A_TCON, 32'd0, "tcon_after_rst");
    rd(A_TL, 32'd0, "tl_after_rst");
    rd(A_DIGI, 32'd0, "digi_after_rst");
    idle();

    repeat (2) @(posedge iClk);
    #6;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
